// File: rtl/arb_pkg.sv
// Shared types and default sizing for the sequential square arbiter.
// EVAL_G is reachable only when the design is built with ARB_PIPE_EN.
package arb_pkg;
  localparam int ARB_SQUARES = 64;
  localparam int ARB_PRIO_W  = 3;
  localparam int ARB_GROUP   = 8;

  typedef enum logic [2:0] {IDLE, EVAL_G, EVAL, OUT, DONE} state_t;
endpackage

// File: rtl/arb_seq_if.sv
// Load / issue handshake bundle between the priority plane, arbiter and search controller.
// The master side drives load/prio_in/out_ready; the arbiter is the slave.
interface arb_seq_if
  import arb_pkg::*;
#(
  parameter int SQUARES = ARB_SQUARES,
  parameter int PRIO_W  = ARB_PRIO_W
);
  localparam int SQ_W = (SQUARES > 1) ? $clog2(SQUARES) : 1;

  logic                      load;
  logic [SQUARES*PRIO_W-1:0] prio_in;
  logic                      out_valid;
  logic                      out_ready;
  logic [SQ_W-1:0]           sq_out;
  logic [PRIO_W-1:0]         prio_out;
  logic                      done;
  logic                      busy;

  modport master (
    output load, prio_in, out_ready,
    input  out_valid, sq_out, prio_out, done, busy
  );

  modport slave (
    input  load, prio_in, out_ready,
    output out_valid, sq_out, prio_out, done, busy
  );
endinterface

// File: rtl/arb_tree.sv
// Combinational max reduction over N (index, priority) pairs; ties keep the earlier
// entry, so with ascending indices the lowest index wins.
module arb_tree #(
  parameter int N      = 8,
  parameter int IDX_W  = 6,
  parameter int PRIO_W = 3
) (
  input  logic [N-1:0][IDX_W-1:0]  idx,
  input  logic [N-1:0][PRIO_W-1:0] prio,
  output logic [IDX_W-1:0]         win_idx,
  output logic [PRIO_W-1:0]        win_prio
);
  always_comb begin
    win_idx  = idx[0];
    win_prio = prio[0];
    for (int i = 1; i < N; i++) begin
      if (prio[i] > win_prio) begin
        win_idx  = idx[i];
        win_prio = prio[i];
      end
    end
  end
endmodule

// File: rtl/arb_seq.sv
// Sequential square arbiter: issues stored squares in descending priority order,
// clearing each on accept. Build option ARB_PIPE_EN registers per-group winners (EVAL_G).
module arb_seq
  import arb_pkg::*;
#(
  parameter int SQUARES = ARB_SQUARES,
  parameter int PRIO_W  = ARB_PRIO_W,
  parameter int GROUP   = ARB_GROUP
) (
  input logic       clk,
  input logic       rst_n,
  arb_seq_if.slave  bus
);
  localparam int SQ_W = (SQUARES > 1) ? $clog2(SQUARES) : 1;
  localparam int NG   = SQUARES / GROUP;

`ifdef ARB_PIPE_EN
  localparam state_t START = EVAL_G;
`else
  localparam state_t START = EVAL;
`endif

  state_t state_q, state_d;

  logic [SQUARES-1:0][PRIO_W-1:0] stored;
  logic [SQ_W-1:0]                sq_q;
  logic [PRIO_W-1:0]              prio_q;

  logic [NG-1:0][GROUP-1:0][SQ_W-1:0] g_idx;
  logic [NG-1:0][SQ_W-1:0]            g_win_idx;
  logic [NG-1:0][PRIO_W-1:0]          g_win_prio;
  logic [NG-1:0][SQ_W-1:0]            top_idx;
  logic [NG-1:0][PRIO_W-1:0]          top_prio;
  logic [SQ_W-1:0]                    win_idx;
  logic [PRIO_W-1:0]                  win_prio;

  logic accept;
  assign accept = (state_q == OUT) && bus.out_ready;

  // First level: one tree per rank, fed with global square indices.
  for (genvar g = 0; g < NG; g++) begin : g_grp
    for (genvar j = 0; j < GROUP; j++) begin : g_ent
      assign g_idx[g][j] = SQ_W'(g * GROUP + j);
    end
    arb_tree #(.N(GROUP), .IDX_W(SQ_W), .PRIO_W(PRIO_W)) u_tree (
      .idx      (g_idx[g]),
      .prio     (stored[g*GROUP +: GROUP]),
      .win_idx  (g_win_idx[g]),
      .win_prio (g_win_prio[g])
    );
  end

`ifdef ARB_PIPE_EN
  logic [NG-1:0][SQ_W-1:0]   g_idx_q;
  logic [NG-1:0][PRIO_W-1:0] g_prio_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      g_idx_q  <= '0;
      g_prio_q <= '0;
    end else if (state_q == EVAL_G) begin
      g_idx_q  <= g_win_idx;
      g_prio_q <= g_win_prio;
    end
  end

  assign top_idx  = g_idx_q;
  assign top_prio = g_prio_q;
`else
  assign top_idx  = g_win_idx;
  assign top_prio = g_win_prio;
`endif

  arb_tree #(.N(NG), .IDX_W(SQ_W), .PRIO_W(PRIO_W)) u_top (
    .idx      (top_idx),
    .prio     (top_prio),
    .win_idx  (win_idx),
    .win_prio (win_prio)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // load restarts from any state and outranks a same-cycle accept.
  always_comb begin
    state_d = state_q;
    if (bus.load) begin
      state_d = START;
    end else begin
      case (state_q)
        IDLE:    state_d = IDLE;
        EVAL_G:  state_d = EVAL;
        EVAL:    state_d = (win_prio == '0) ? DONE : OUT;
        OUT:     if (bus.out_ready) state_d = START;
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stored <= '0;
      sq_q   <= '0;
      prio_q <= '0;
    end else if (bus.load) begin
      stored <= bus.prio_in;
    end else begin
      if (accept) stored[sq_q] <= '0;
      if (state_q == EVAL) begin
        sq_q   <= win_idx;
        prio_q <= win_prio;
      end
    end
  end

  assign bus.out_valid = (state_q == OUT);
  assign bus.done      = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE) && (state_q != DONE);
  assign bus.sq_out    = sq_q;
  assign bus.prio_out  = prio_q;
endmodule

// File: tb/tb_arb_seq.sv
// Self-checking bench for arb_seq: scenario tasks against a max-then-first-index model.
// Latency expectations follow ARB_PIPE_EN when the bench is built with it.
module tb_arb_seq;
  localparam int SQUARES = 64;
  localparam int PRIO_W  = 3;
  localparam int GROUP   = 8;
`ifdef ARB_PIPE_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  arb_seq_if #(.SQUARES(SQUARES), .PRIO_W(PRIO_W)) bus ();
  arb_seq #(.SQUARES(SQUARES), .PRIO_W(PRIO_W), .GROUP(GROUP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;
  int mdl[SQUARES];

  // Reference winner: find the maximum value, then the first square holding it.
  function automatic void winner(output int sq, output int pr);
    pr = 0;
    for (int i = 0; i < SQUARES; i++) if (mdl[i] > pr) pr = mdl[i];
    sq = 0;
    for (int i = 0; i < SQUARES; i++) if (mdl[i] == pr) begin sq = i; break; end
  endfunction

  function automatic int nonzero_cnt();
    int n = 0;
    for (int i = 0; i < SQUARES; i++) if (mdl[i] != 0) n++;
    return n;
  endfunction

  function automatic logic [SQUARES*PRIO_W-1:0] packed_vec();
    logic [SQUARES*PRIO_W-1:0] v;
    v = '0;
    for (int i = 0; i < SQUARES; i++) v[PRIO_W*i +: PRIO_W] = PRIO_W'(mdl[i]);
    return v;
  endfunction

  task automatic clear_mdl();
    for (int i = 0; i < SQUARES; i++) mdl[i] = 0;
  endtask

  task automatic rand_mdl(input int density);
    for (int i = 0; i < SQUARES; i++)
      mdl[i] = ($urandom_range(0, 99) < density) ? int'($urandom_range(1, 7)) : 0;
  endtask

  // All stimulus tasks start and end on a negedge.
  task automatic start_load();
    bus.load = 1'b1;
    bus.prio_in = packed_vec();
    @(negedge clk);
    bus.load = 1'b0;
  endtask

  task automatic pulse_accept();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  // Counts negedges since the triggering pulse until out_valid or done (bounded).
  task automatic wait_resp(output int k);
    k = 1;
    while (!(bus.out_valid || bus.done) && k <= 12) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic test_reset();
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_in_valid got=%b exp=0", bus.out_valid); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.sq_out !== '0 || bus.prio_out !== '0) begin failures++; $display("FAIL reset_outs got=%0d/%0d exp=0/0", bus.sq_out, bus.prio_out); end
  endtask

  task automatic test_basic();
    int k;
    clear_mdl(); mdl[5] = 3; mdl[40] = 6;
    start_load();
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL basic_early_valid got=%b exp=0", bus.out_valid); end
    wait_resp(k);
    checks++; if (k != LAT || bus.out_valid !== 1'b1) begin failures++; $display("FAIL basic_lat got=%0d exp=%0d", k, LAT); end
    checks++; if (int'(bus.sq_out) != 40 || int'(bus.prio_out) != 6) begin failures++; $display("FAIL basic_first got=%0d/%0d exp=40/6", bus.sq_out, bus.prio_out); end
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL basic_busy got=%b exp=1", bus.busy); end
    pulse_accept();
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL basic_drop got=%b exp=0", bus.out_valid); end
    wait_resp(k);
    checks++; if (k != LAT || int'(bus.sq_out) != 5 || int'(bus.prio_out) != 3) begin failures++; $display("FAIL basic_second got=%0d/%0d lat=%0d exp=5/3 lat=%0d", bus.sq_out, bus.prio_out, k, LAT); end
    pulse_accept();
    wait_resp(k);
    checks++; if (k != LAT || bus.done !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin failures++; $display("FAIL basic_done got=lat%0d done%b valid%b busy%b exp=lat%0d 1 0 0", k, bus.done, bus.out_valid, bus.busy, LAT); end
  endtask

  task automatic test_ties();
    int k;
    int exp_sq[3] = '{9, 17, 63};
    clear_mdl(); mdl[9] = 7; mdl[17] = 7; mdl[63] = 7;
    start_load();
    for (int n = 0; n < 3; n++) begin
      wait_resp(k);
      checks++; if (k != LAT || bus.out_valid !== 1'b1 || int'(bus.sq_out) != exp_sq[n] || int'(bus.prio_out) != 7) begin failures++; $display("FAIL ties_issue%0d got=%0d/%0d lat=%0d exp=%0d/7 lat=%0d", n, bus.sq_out, bus.prio_out, k, exp_sq[n], LAT); end
      pulse_accept();
    end
    wait_resp(k);
    checks++; if (bus.done !== 1'b1 || bus.out_valid !== 1'b0) begin failures++; $display("FAIL ties_done got=done%b valid%b exp=1 0", bus.done, bus.out_valid); end
  endtask

  task automatic test_backpressure();
    int k, esq, epr, n, issues;
    rand_mdl(30); mdl[2] = 4; mdl[50] = 5;
    start_load();
    wait_resp(k);
    winner(esq, epr);
    checks++; if (int'(bus.sq_out) != esq || int'(bus.prio_out) != epr) begin failures++; $display("FAIL bp_first got=%0d/%0d exp=%0d/%0d", bus.sq_out, bus.prio_out, esq, epr); end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++; if (bus.out_valid !== 1'b1 || int'(bus.sq_out) != esq || int'(bus.prio_out) != epr) begin failures++; $display("FAIL bp_hold%0d got=%b %0d/%0d exp=1 %0d/%0d", c, bus.out_valid, bus.sq_out, bus.prio_out, esq, epr); end
    end
    pulse_accept();
    mdl[esq] = 0;
    n = nonzero_cnt();
    issues = 0;
    forever begin
      wait_resp(k);
      if (k > 12) begin checks++; failures++; $display("FAIL bp_timeout got=none exp=response"); break; end
      if (bus.done) break;
      winner(esq, epr);
      checks++; if (int'(bus.sq_out) != esq || int'(bus.prio_out) != epr) begin failures++; $display("FAIL bp_drain got=%0d/%0d exp=%0d/%0d", bus.sq_out, bus.prio_out, esq, epr); end
      mdl[esq] = 0;
      issues++;
      if (issues > SQUARES) break;
      pulse_accept();
    end
    checks++; if (issues != n) begin failures++; $display("FAIL bp_count got=%0d exp=%0d", issues, n); end
  endtask

  task automatic test_zero();
    int k;
    logic seen_valid = 1'b0;
    clear_mdl();
    start_load();
    for (k = 1; k < LAT; k++) begin
      seen_valid |= bus.out_valid;
      @(negedge clk);
    end
    checks++; if (bus.done !== 1'b1) begin failures++; $display("FAIL zero_done got=%b exp=1", bus.done); end
    for (int c = 0; c < 3; c++) begin
      seen_valid |= bus.out_valid;
      @(negedge clk);
    end
    checks++; if (seen_valid !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b1) begin failures++; $display("FAIL zero_quiet got=valid%b busy%b done%b exp=0 0 1", seen_valid, bus.busy, bus.done); end
  endtask

  task automatic test_load_accept();
    int k, w, esq, epr;
    rand_mdl(40); mdl[30] = 3;
    start_load();
    wait_resp(k);
    w = int'(bus.sq_out);
    // New vector where the in-flight winner is again the winner.
    for (int i = 0; i < SQUARES; i++) mdl[i] = (i < w) ? int'($urandom_range(0, 6)) : int'($urandom_range(0, 7));
    mdl[w] = 7;
    bus.out_ready = 1'b1;
    bus.load = 1'b1;
    bus.prio_in = packed_vec();
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.load = 1'b0;
    wait_resp(k);
    checks++; if (k != LAT || int'(bus.sq_out) != w || int'(bus.prio_out) != 7) begin failures++; $display("FAIL la_winner got=%0d/%0d lat=%0d exp=%0d/7 lat=%0d", bus.sq_out, bus.prio_out, k, w, LAT); end
    pulse_accept();
    mdl[w] = 0;
    wait_resp(k);
    winner(esq, epr);
    checks++; if (int'(bus.sq_out) != esq || int'(bus.prio_out) != epr || bus.out_valid !== (epr != 0)) begin failures++; $display("FAIL la_next got=%0d/%0d exp=%0d/%0d", bus.sq_out, bus.prio_out, esq, epr); end
  endtask

  task automatic test_reset_mid();
    int k;
    clear_mdl(); mdl[11] = 2; mdl[44] = 5;
    start_load();
    wait_resp(k);
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL rm_pre got=%b exp=1", bus.out_valid); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.done !== 1'b0 || bus.busy !== 1'b0) begin failures++; $display("FAIL rm_async got=valid%b done%b busy%b exp=0 0 0", bus.out_valid, bus.done, bus.busy); end
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++; if (bus.out_valid !== 1'b0 || bus.done !== 1'b0 || bus.busy !== 1'b0) begin failures++; $display("FAIL rm_idle%0d got=valid%b done%b busy%b exp=0 0 0", c, bus.out_valid, bus.done, bus.busy); end
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_random();
    int k, esq, epr, issues, hold;
    for (int r = 0; r < 5; r++) begin
      if (r == 0) begin
        epr = int'($urandom_range(1, 7));
        for (int i = 0; i < SQUARES; i++) mdl[i] = epr;
      end else begin
        rand_mdl(10 + 20 * r);
      end
      start_load();
      issues = 0;
      forever begin
        wait_resp(k);
        checks++; if (k != LAT) begin failures++; $display("FAIL rnd%0d_lat got=%0d exp=%0d", r, k, LAT); break; end
        winner(esq, epr);
        if (bus.done) begin
          checks++; if (epr != 0 || bus.out_valid !== 1'b0) begin failures++; $display("FAIL rnd%0d_early_done got=done exp=%0d/%0d", r, esq, epr); end
          break;
        end
        checks++; if (int'(bus.sq_out) != esq || int'(bus.prio_out) != epr) begin failures++; $display("FAIL rnd%0d_issue got=%0d/%0d exp=%0d/%0d", r, bus.sq_out, bus.prio_out, esq, epr); end
        hold = int'($urandom_range(0, 2));
        repeat (hold) @(negedge clk);
        checks++; if (bus.out_valid !== 1'b1 || int'(bus.sq_out) != esq) begin failures++; $display("FAIL rnd%0d_stable got=%b %0d exp=1 %0d", r, bus.out_valid, bus.sq_out, esq); end
        pulse_accept();
        mdl[esq] = 0;
        issues++;
        if (issues > SQUARES) begin checks++; failures++; $display("FAIL rnd%0d_overrun got=%0d exp<=%0d", r, issues, SQUARES); break; end
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.load = 1'b0;
    bus.out_ready = 1'b0;
    bus.prio_in = '0;
    repeat (2) @(negedge clk);
    test_reset();
    test_basic();
    test_ties();
    test_backpressure();
    test_zero();
    test_load_accept();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
